multi_channel_bus_switch: RTL and testbench
===========================================

// Module: multi_channel_bus_switch
// PURPOSE
//   Parametrised, registered successor to the 8-bit enable switch: N WIDTH-bit
//   input channels, each with its own enable, share one output bus. Selection is
//   fixed-priority or round-robin. A drive conflict (more than one enable high)
//   is flagged and counted instead of being silently merged. Used wherever
//   several custom components drive a shared bus, e.g. the memory or ALU result bus.
// PARAMETERS
//   WIDTH     8   data width per channel, >= 1
//   CHANNELS  4   number of input channels, 1..16
//   RR_MODE   0   0 = fixed priority, lowest index wins; 1 = round-robin
//   HOLD      0   0 = out_data goes to 0 when idle; 1 = out_data keeps last value
//   SEL_W     max(1,$clog2(CHANNELS))  localparam, width of out_sel
// PORTS
//   clk             in   1               clock, rising edge
//   rst             in   1               synchronous reset, active-high
//   in_data         in   WIDTH*CHANNELS  channel k occupies bits [k*WIDTH +: WIDTH]
//   in_en           in   CHANNELS        per-channel enable (drive request)
//   out_data        out  WIDTH           registered selected data
//   out_valid       out  1               registered; 1 = out_data driven this cycle
//   out_sel         out  SEL_W           registered index of granted channel
//   conflict        out  1               registered; 1 = >1 enable sampled
//   conflict_count  out  8               saturating count of conflict cycles
// BEHAVIOUR
//   - One clock and one reset. Reset is synchronous and active-high. All state
//     is updated on the rising edge of clk.
//   - Reset: out_data=0, out_valid=0, out_sel=0, conflict=0, conflict_count=0,
//     and the round-robin pointer rr_ptr=0. Reset takes priority over all inputs.
//     Reset asserted mid-stream clears everything on that edge. The first grant
//     after reset follows the reset values.
//   - Latency: exactly 1 cycle. Inputs sampled at edge t appear on outputs after t.
//   - Grant, when any in_en is high:
//       RR_MODE=0: grant the lowest set index.
//       RR_MODE=1: grant the first set index found by searching rr_ptr,
//       rr_ptr+1, ... modulo CHANNELS. Then rr_ptr <= (grant+1) mod CHANNELS.
//       The wrap from CHANNELS-1 goes to 0.
//     On a grant: out_data <= granted channel's data, out_valid <= 1,
//     out_sel <= grant.
//   - Idle (in_en == 0):
//       out_valid <= 0.
//       out_sel holds its value.
//       rr_ptr holds its value.
//       out_data <= 0 if HOLD=0, or holds its value if HOLD=1.
//   - Conflict:
//       conflict <= 1 if popcount(in_en) > 1, else 0.
//       conflict_count increments on each conflict cycle and saturates at 255
//       (no wrap).
//       A conflict still produces a normal grant. Data is never OR-merged.
//   - CHANNELS=1: out_sel is constant 0, conflict is never set, and the round-robin
//     pointer stays 0.
//   - Purely synchronous. No tri-state and no latches. Outputs are defined
//     (never X) after the first reset.
// TESTING
//   1 Reset: hold rst for 2 cycles with random inputs -> all outputs 0. Then set
//     in_en=0 -> out_valid stays 0.
//   2 Single driver: W=8, N=4, in_en=4'b0100, ch2=8'hA5 -> the next cycle gives
//     out_data=A5, out_valid=1, out_sel=2, conflict=0.
//   3 Priority conflict: RR_MODE=0, in_en=4'b1010, ch1=11, ch3=33 -> out_data=11,
//     out_sel=1, conflict=1, conflict_count=1.
//   4 Round-robin fairness: RR_MODE=1, in_en=4'b1111 for 8 cycles -> out_sel
//     sequence 0,1,2,3,0,1,2,3. conflict_count=8.
//   5 Idle/HOLD: grant ch0=8'h3C, then in_en=0 -> HOLD=0 gives out_data=0;
//     HOLD=1 gives out_data=3C. In both cases out_valid=0 and out_sel=0.
//   6 Saturation/reset: 300 conflict cycles -> conflict_count=255. Then assert
//     rst for 1 cycle -> count=0, and the next RR grant searches from ch0.

Source files
------------

// File: rtl/multi_channel_bus_switch.sv
// Shared-bus switch: N enabled channels contend for one registered output bus.
// Grant is fixed-priority (lowest index) or round-robin from a rotating pointer.
// Multiple simultaneous enables are flagged and counted, never data-merged.
module multi_channel_bus_switch #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int RR_MODE  = 0,
    parameter int HOLD     = 0,
    localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH*CHANNELS-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_en,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    output logic [SEL_W-1:0]          out_sel,
    output logic                      conflict,
    output logic [7:0]                conflict_count
);

    logic [SEL_W-1:0]    rr_ptr;
    logic [SEL_W-1:0]    base;
    logic [CHANNELS-1:0] rot;
    logic [SEL_W-1:0]    off;
    logic [SEL_W-1:0]    rem;
    logic [SEL_W-1:0]    grant;
    logic [SEL_W-1:0]    ptr_next;
    logic [WIDTH-1:0]    sel_data;
    logic                found;
    logic                seen;
    logic                multi;
    logic                any_en;

    // Grant selection: rotate enables so the search always starts at bit 0,
    // then map the found offset back to an absolute channel index mod CHANNELS.
    // rem is CHANNELS-base in SEL_W bits; for power-of-two CHANNELS it wraps to
    // 0 when base=0, which still yields grant=off.
    always_comb begin
        any_en = |in_en;
        base   = (RR_MODE != 0) ? rr_ptr : '0;
        rot    = CHANNELS'({in_en, in_en} >> base);
        off    = '0;
        found  = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!found && rot[i]) begin
                off   = SEL_W'(i);
                found = 1'b1;
            end
        end
        rem = SEL_W'(CHANNELS) - base;
        if (off >= rem) grant = off - rem;
        else            grant = base + off;
    end

    // Conflict detect, data mux for the granted channel, and next RR pointer.
    always_comb begin
        seen     = 1'b0;
        multi    = 1'b0;
        sel_data = '0;
        for (int j = 0; j < CHANNELS; j++) begin
            if (in_en[j]) begin
                if (seen) multi = 1'b1;
                seen = 1'b1;
            end
            if (grant == SEL_W'(j)) sel_data = in_data[j*WIDTH +: WIDTH];
        end
        if (grant == SEL_W'(CHANNELS - 1)) ptr_next = '0;
        else                               ptr_next = grant + SEL_W'(1);
    end

    // Output, pointer and conflict-counter registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data       <= '0;
            out_valid      <= 1'b0;
            out_sel        <= '0;
            conflict       <= 1'b0;
            conflict_count <= '0;
            rr_ptr         <= '0;
        end else begin
            conflict <= multi;
            if (multi && (conflict_count != 8'hFF)) conflict_count <= conflict_count + 8'd1;
            if (any_en) begin
                out_data  <= sel_data;
                out_valid <= 1'b1;
                out_sel   <= grant;
                if (RR_MODE != 0) rr_ptr <= ptr_next;
            end else begin
                out_valid <= 1'b0;
                if (HOLD == 0) out_data <= '0;
            end
        end
    end

endmodule

// File: tb/tb_multi_channel_bus_switch.sv
// Bench for multi_channel_bus_switch: four parameter variants share one stimulus,
// a behavioural model predicts every output each cycle, plus literal spot checks.
module tb_multi_channel_bus_switch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_data = '0;
    logic [3:0]  in_en = '0;

    int n_total = 0;
    int n_pass  = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    // instance 0: N=4 priority, HOLD=0
    logic [7:0] p0_data; logic p0_valid; logic [1:0] p0_sel; logic p0_conf; logic [7:0] p0_cnt;
    // instance 1: N=4 round-robin, HOLD=1
    logic [7:0] r1_data; logic r1_valid; logic [1:0] r1_sel; logic r1_conf; logic [7:0] r1_cnt;
    // instance 2: N=3 round-robin, HOLD=0
    logic [7:0] n3_data; logic n3_valid; logic [1:0] n3_sel; logic n3_conf; logic [7:0] n3_cnt;
    // instance 3: N=1 priority, HOLD=1
    logic [7:0] c1_data; logic c1_valid; logic [0:0] c1_sel; logic c1_conf; logic [7:0] c1_cnt;

    multi_channel_bus_switch #(.WIDTH(8), .CHANNELS(4), .RR_MODE(0), .HOLD(0)) u_p0 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_en(in_en),
        .out_data(p0_data), .out_valid(p0_valid), .out_sel(p0_sel),
        .conflict(p0_conf), .conflict_count(p0_cnt));

    multi_channel_bus_switch #(.WIDTH(8), .CHANNELS(4), .RR_MODE(1), .HOLD(1)) u_r1 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_en(in_en),
        .out_data(r1_data), .out_valid(r1_valid), .out_sel(r1_sel),
        .conflict(r1_conf), .conflict_count(r1_cnt));

    multi_channel_bus_switch #(.WIDTH(8), .CHANNELS(3), .RR_MODE(1), .HOLD(0)) u_n3 (
        .clk(clk), .rst(rst), .in_data(in_data[23:0]), .in_en(in_en[2:0]),
        .out_data(n3_data), .out_valid(n3_valid), .out_sel(n3_sel),
        .conflict(n3_conf), .conflict_count(n3_cnt));

    multi_channel_bus_switch #(.WIDTH(8), .CHANNELS(1), .RR_MODE(0), .HOLD(1)) u_c1 (
        .clk(clk), .rst(rst), .in_data(in_data[7:0]), .in_en(in_en[0:0]),
        .out_data(c1_data), .out_valid(c1_valid), .out_sel(c1_sel),
        .conflict(c1_conf), .conflict_count(c1_cnt));

    // model configuration and state, one slot per instance
    int m_n    [4] = '{4, 4, 3, 1};
    bit m_rr   [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    bit m_hold [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    int m_data [4];
    int m_valid[4];
    int m_sel  [4];
    int m_conf [4];
    int m_cnt  [4];
    int m_ptr  [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    // Apply the switching rules to the inputs sampled at this edge.
    task automatic model_step(input int k);
        int en_k, g, idx, ones, start;
        en_k = int'(in_en) & ((1 << m_n[k]) - 1);
        if (rst) begin
            m_data[k] = 0; m_valid[k] = 0; m_sel[k] = 0;
            m_conf[k] = 0; m_cnt[k] = 0; m_ptr[k] = 0;
            return;
        end
        ones = $countones(en_k);
        m_conf[k] = (ones > 1) ? 1 : 0;
        if (ones > 1 && m_cnt[k] < 255) m_cnt[k] = m_cnt[k] + 1;
        if (en_k != 0) begin
            g = -1;
            start = m_rr[k] ? m_ptr[k] : 0;
            for (int i = 0; i < m_n[k]; i++) begin
                idx = (start + i) % m_n[k];
                if (g < 0 && ((en_k >> idx) & 1) == 1) g = idx;
            end
            m_data[k]  = int'(in_data >> (g * 8)) & 8'hFF;
            m_valid[k] = 1;
            m_sel[k]   = g;
            if (m_rr[k]) m_ptr[k] = (g + 1) % m_n[k];
        end else begin
            m_valid[k] = 0;
            if (!m_hold[k]) m_data[k] = 0;
        end
    endtask

    task automatic tick(input bit r, input logic [3:0] e, input logic [31:0] d);
        rst = r; in_en = e; in_data = d;
        @(posedge clk);
        for (int k = 0; k < 4; k++) model_step(k);
        if (r) started = 1'b1;
        #1;
    endtask

    task automatic cmp_inst(input int k, input string nm, input logic [7:0] d, input logic v,
                            input logic [31:0] s, input logic c, input logic [7:0] cc);
        chk({nm, "_data"},  32'(d),  32'(m_data[k]));
        chk({nm, "_valid"}, 32'(v),  32'(m_valid[k]));
        chk({nm, "_sel"},   s,       32'(m_sel[k]));
        chk({nm, "_conf"},  32'(c),  32'(m_conf[k]));
        chk({nm, "_cnt"},   32'(cc), 32'(m_cnt[k]));
    endtask

    // Every-cycle comparison of all instances against the model.
    always @(negedge clk) begin
        if (started) begin
            cmp_inst(0, "p0", p0_data, p0_valid, 32'(p0_sel), p0_conf, p0_cnt);
            cmp_inst(1, "r1", r1_data, r1_valid, 32'(r1_sel), r1_conf, r1_cnt);
            cmp_inst(2, "n3", n3_data, n3_valid, 32'(n3_sel), n3_conf, n3_cnt);
            cmp_inst(3, "c1", c1_data, c1_valid, 32'(c1_sel), c1_conf, c1_cnt);
        end
    end

    initial begin
        // reset with random inputs
        tick(1'b1, 4'($urandom), $urandom);
        tick(1'b1, 4'($urandom), $urandom);
        chk("rst_p0_data", 32'(p0_data), 32'h0);
        chk("rst_p0_valid", 32'(p0_valid), 32'h0);
        chk("rst_r1_cnt", 32'(r1_cnt), 32'h0);
        chk("rst_r1_sel", 32'(r1_sel), 32'h0);
        tick(1'b0, 4'b0000, 32'hFFFF_FFFF);
        chk("idle_p0_valid", 32'(p0_valid), 32'h0);

        // single driver
        tick(1'b0, 4'b0100, 32'h00A5_0000);
        chk("single_data", 32'(p0_data), 32'hA5);
        chk("single_valid", 32'(p0_valid), 32'h1);
        chk("single_sel", 32'(p0_sel), 32'h2);
        chk("single_conf", 32'(p0_conf), 32'h0);

        // priority conflict; RR instance resumes from pointer 3
        tick(1'b0, 4'b1010, 32'h3300_1100);
        chk("prio_data", 32'(p0_data), 32'h11);
        chk("prio_sel", 32'(p0_sel), 32'h1);
        chk("prio_conf", 32'(p0_conf), 32'h1);
        chk("prio_cnt", 32'(p0_cnt), 32'h1);
        chk("rr_resume_sel", 32'(r1_sel), 32'h3);
        chk("rr_resume_data", 32'(r1_data), 32'h33);

        // round-robin fairness from reset
        tick(1'b1, 4'b0000, 32'h0);
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 4'b1111, 32'h4433_2211);
            chk("rr_seq_sel", 32'(r1_sel), 32'(i % 4));
            chk("rr_seq_data", 32'(r1_data), 32'(8'h11 + 8'h11 * (i % 4)));
        end
        chk("rr_cnt8", 32'(r1_cnt), 32'd8);
        chk("prio_seq_sel", 32'(p0_sel), 32'h0);

        // three-channel wrap
        tick(1'b1, 4'b0000, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 4'b0111, 32'h0033_2211);
            chk("n3_wrap_sel", 32'(n3_sel), 32'(i % 3));
        end
        chk("c1_conf", 32'(c1_conf), 32'h0);

        // idle with and without hold
        tick(1'b1, 4'b0000, 32'h0);
        tick(1'b0, 4'b0001, 32'h0000_003C);
        tick(1'b0, 4'b0000, 32'h5555_5555);
        chk("hold0_data", 32'(p0_data), 32'h0);
        chk("hold0_valid", 32'(p0_valid), 32'h0);
        chk("hold0_sel", 32'(p0_sel), 32'h0);
        chk("hold1_data", 32'(r1_data), 32'h3C);
        chk("hold1_valid", 32'(r1_valid), 32'h0);
        chk("hold1_sel", 32'(r1_sel), 32'h0);

        // saturation, then mid-stream reset
        for (int i = 0; i < 300; i++) begin
            tick(1'b0, 4'b1111, $urandom);
            if (i == 254) chk("sat_reach", 32'(p0_cnt), 32'd255);
        end
        chk("sat_p0_cnt", 32'(p0_cnt), 32'd255);
        chk("sat_r1_cnt", 32'(r1_cnt), 32'd255);
        tick(1'b0, 4'b0010, 32'h0000_7700);
        chk("pre_rst_sel", 32'(r1_sel), 32'h1);
        tick(1'b1, 4'b1111, 32'hDEAD_BEEF);
        chk("rst_mid_cnt", 32'(r1_cnt), 32'h0);
        chk("rst_mid_valid", 32'(r1_valid), 32'h0);
        tick(1'b0, 4'b1111, 32'h4433_2211);
        chk("post_rst_sel", 32'(r1_sel), 32'h0);
        chk("post_rst_cnt", 32'(p0_cnt), 32'h1);

        // random mix, checked by the model every cycle
        for (int i = 0; i < 60; i++) tick(1'b0, 4'($urandom), $urandom);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
